// File: rtl/mux16_result_stage_pkg.sv
// Shared types and constants for the mux16 result stage.
package mux16_result_stage_pkg;

  localparam int ALU_W = 16;

  // One buffered result: mux output plus the select bit that produced it.
  typedef struct packed {
    logic [ALU_W-1:0] data;
    logic             sel;
  } entry_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/mux16_result_stage_flags.sv
// Zero / negative detect on the head data word.
module result_flags #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             zero_o,
  output logic             neg_o
);

  // Pure combinational flag decode.
  always_comb begin
    zero_o = (data_i == '0);
    neg_o  = data_i[WIDTH-1];
  end

endmodule

// File: rtl/mux16_result_stage.sv
// Two-entry skid buffer behind the mux16 operand mux, with result flags and
// a wrapping delivered-result counter.
module mux16_result_stage
  import mux16_result_stage_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] count
);

  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  entry_t           in_entry;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q;
  logic             push, pop;
  logic             head_zero, head_neg;

  assign in_entry  = '{data: in_data, sel: in_sel};
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = head_q.data;
  assign out_sel   = head_q.sel;
  assign count     = count_q;

  result_flags #(.WIDTH(WIDTH)) u_flags (
    .data_i (head_q.data),
    .zero_o (head_zero),
    .neg_o  (head_neg)
  );

  // Flags only mean something while the head entry is valid.
  always_comb begin
    out_zero = out_valid & head_zero;
    out_neg  = out_valid & head_neg;
  end

  // Occupancy transitions, entry moves and pop counting; clr overrides all.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    count_d = pop ? count_q + 1'b1 : count_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          head_d = in_entry;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_d = in_entry;
        end else if (push) begin
          tail_d = in_entry;
          occ_d  = OCC_FULL;
        end else if (pop) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    if (clr) begin
      occ_d   = OCC_EMPTY;
      count_d = '0;
    end
  end

  // State registers; in_ready is registered from next occupancy so it has no
  // combinational path from out_ready, and stays low while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= OCC_EMPTY;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      count_q    <= count_d;
      in_ready_q <= (occ_d != OCC_FULL);
    end
  end

endmodule

// File: tb/tb_mux16_result_stage.sv
// Directed bench for mux16_result_stage.
module tb_mux16_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sel;
  logic        out_zero;
  logic        out_neg;
  logic [15:0] count;

  int errors = 0;
  int checks = 0;

  mux16_result_stage #(.WIDTH(16), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 1'b0; out_ready = 1'b0;

    // Reset
    repeat (3) tick();
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_flags", 32'({out_zero, out_neg, out_sel}), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_out_valid", 32'(out_valid), 32'd0);
    check("rel_count", 32'(count), 32'd0);
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Single transfer
    in_valid = 1'b1; in_data = 16'h8000; in_sel = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("st_valid", 32'(out_valid), 32'd1);
    check("st_data", 32'(out_data), 32'h8000);
    check("st_sel", 32'(out_sel), 32'd1);
    check("st_neg", 32'(out_neg), 32'd1);
    check("st_zero", 32'(out_zero), 32'd0);
    tick();
    check("st_after_valid", 32'(out_valid), 32'd0);
    check("st_count", 32'(count), 32'd1);
    check("st_flags_idle", 32'({out_zero, out_neg}), 32'd0);

    // Backpressure and fill
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0000; in_sel = 1'b0;
    tick();
    check("bp_ready_one", 32'(in_ready), 32'd1);
    in_data = 16'h1234; in_sel = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_head_data", 32'(out_data), 32'h0000);
    check("bp_head_sel", 32'(out_sel), 32'd0);
    check("bp_zero", 32'(out_zero), 32'd1);
    check("bp_neg", 32'(out_neg), 32'd0);
    tick();
    check("bp_hold_data", 32'(out_data), 32'h0000);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_ready", 32'(in_ready), 32'd0);

    // Drain order
    out_ready = 1'b1;
    tick();
    check("dr_data1", 32'(out_data), 32'h1234);
    check("dr_sel1", 32'(out_sel), 32'd1);
    check("dr_valid1", 32'(out_valid), 32'd1);
    check("dr_zero1", 32'(out_zero), 32'd0);
    check("dr_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("dr_empty", 32'(out_valid), 32'd0);
    check("dr_count", 32'(count), 32'd2);

    // Steady streaming at occupancy 1
    clr = 1'b1;
    tick();
    clr = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'd0; in_sel = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_data = 16'(i); in_sel = i[0];
      tick();
      check("sm_in_ready", 32'(in_ready), 32'd1);
      check("sm_valid", 32'(out_valid), 32'd1);
      check("sm_data", 32'(out_data), 32'(i));
      check("sm_sel", 32'(out_sel), 32'(i[0]));
    end
    check("sm_count", 32'(count), 32'd100);
    in_valid = 1'b0;
    tick();
    check("sm_count_last", 32'(count), 32'd101);
    check("sm_empty", 32'(out_valid), 32'd0);

    // Flush with push while full
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hAAAA; in_sel = 1'b1;
    tick();
    in_data = 16'h5555; in_sel = 1'b0;
    tick();
    check("fl_full", 32'(in_ready), 32'd0);
    clr = 1'b1; in_data = 16'hBEEF; in_sel = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_count", 32'(count), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("fl_dropped", 32'(out_valid), 32'd0);

    // Pop coinciding with clr does not count
    in_valid = 1'b1; in_data = 16'h0042; in_sel = 1'b0;
    tick();
    in_valid = 1'b0; out_ready = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clrpop_count", 32'(count), 32'd0);
    check("clrpop_valid", 32'(out_valid), 32'd0);

    // Counter wrap
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'd0; in_sel = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      in_data = 16'(i);
      tick();
    end
    check("wr_count_max", 32'(count), 32'hFFFF);
    check("wr_head", 32'(out_data), 32'hFFFF);
    check("wr_neg", 32'(out_neg), 32'd1);
    in_valid = 1'b0;
    tick();
    check("wr_count_wrap", 32'(count), 32'd0);
    check("wr_empty", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
